// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalt
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] PC_STEP           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam int unsigned DEFAULT_BUF_DEPTH = 4;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: redirect input, instruction-memory port and decode handshake.
interface fetch_ctrl_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        misalign;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output if_valid,
        output if_pc,
        output if_instr,
        input  if_ready,
        output misalign
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  if_valid,
        input  if_pc,
        input  if_instr,
        output if_ready,
        input  misalign
    );

endinterface

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush beats push and pop.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_BUF_DEPTH,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  fetch_entry_t    wdata,
    output logic [CntW-1:0] count,
    output fetch_entry_t    head
);

    localparam logic [CntW-1:0] Full = DEPTH[CntW-1:0];

    fetch_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    always_comb begin
        do_pop  = pop && (count_q != '0);
        // A full buffer can still accept a word that replaces the one leaving.
        do_push = push && ((count_q != Full) || do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_comb begin
        count = count_q;
        head  = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one imem read per cycle, buffers words for decode.
// Define FETCH_CTRL_MISALIGN_EN to halt on a misaligned redirect and raise sticky misalign.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
    input logic          clk,
    input logic          rst,
    fetch_ctrl_if.master bus
);

    localparam int unsigned   CntW     = $clog2(BUF_DEPTH) + 1;
    localparam logic [CntW:0] DepthOcc = BUF_DEPTH[CntW:0];

    fetch_state_e    state_q, state_d;
    logic [31:0]     pc_q;
    logic [31:0]     req_pc_q;
    logic            inflight_q;
    logic            epoch_q;
    logic            req_epoch_q;

    logic [CntW-1:0] buf_count;
    fetch_entry_t    buf_head;
    fetch_entry_t    resp_entry;
    logic [CntW:0]   occupancy;
    logic            issue;
    logic            head_valid;
    logic            push;
    logic            pop;
    logic            redir_bad;
    logic [31:0]     redir_pc;

`ifdef FETCH_CTRL_MISALIGN_EN
    logic misalign_q;

    assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign redir_pc  = bus.redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redir_bad) begin
            misalign_q <= 1'b1;
        end
    end

    assign bus.misalign = misalign_q;
`else
    logic unused_redirect_lsb;

    assign redir_bad           = 1'b0;
    assign redir_pc            = {bus.redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
    assign bus.misalign        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = redir_bad ? StHalt : StRun;
            StRun:   if (redir_bad) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StBoot;
        endcase
    end

    // Outputs. Occupancy counts the in-flight word so a response always has a slot.
    always_comb begin
        occupancy  = {1'b0, buf_count} + {{CntW{1'b0}}, inflight_q};
        issue      = (state_q == StRun) && !bus.redirect_valid && (occupancy < DepthOcc);
        head_valid = (state_q == StRun) && (buf_count != '0);

        bus.imem_req  = issue;
        bus.imem_addr = pc_q;
        bus.if_valid  = head_valid;
        bus.if_pc     = head_valid ? buf_head.pc    : '0;
        bus.if_instr  = head_valid ? buf_head.instr : '0;
    end

    // Words from an older epoch belong to a flushed stream and are discarded.
    always_comb begin
        push       = inflight_q && (req_epoch_q == epoch_q);
        pop        = head_valid && bus.if_ready;
        resp_entry = '{pc: req_pc_q, instr: bus.imem_rdata};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            epoch_q     <= 1'b0;
            req_epoch_q <= 1'b0;
        end else begin
            inflight_q  <= issue;
            req_epoch_q <= epoch_q;
            if (issue) begin
                req_pc_q <= pc_q;
            end
            if (bus.redirect_valid) begin
                pc_q       <= redir_pc;
                epoch_q    <= ~epoch_q;
                inflight_q <= 1'b0;
            end else if (issue) begin
                pc_q <= next_pc(pc_q);
            end
        end
    end

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .wdata (resp_entry),
        .count (buf_count),
        .head  (buf_head)
    );

endmodule
